shift_counter_n: RTL and testbench

- Parametrised shift-register counter; generalises the fixed 4-bit ring counter to WIDTH bits.
- Runtime-selectable ring or Johnson (twisted-ring) mode, with direction control, enable, parallel load, illegal-state detection/self-correction, and a wrap pulse.
- Used as a one-hot/thermometer sequencer or timing-phase generator in lab datapaths and FSM exercises.

---
 rtl/shift_counter_n_pkg.sv | 8 +
 rtl/shift_counter_n_state_chk.sv | 37 +++
 rtl/shift_counter_n.sv | 78 +++++++
 tb/tb_shift_counter_n.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/shift_counter_n_pkg.sv
// Shared definitions for the shift-register counter family: the counting-mode
// encodings used by the counter and its state checker.
package shift_counter_n_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;

endpackage : shift_counter_n_pkg

// File: rtl/shift_counter_n_state_chk.sv
// Combinational legality check and home value for a ring / Johnson shift state.
// Reusable by any sequencer built on the same two encodings.
module shift_state_chk
    import shift_counter_n_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             mode_i,
    output logic             legal_o,
    output logic [WIDTH-1:0] home_o
);

    // At most one bit set (x & (x-1) clears the lowest set bit).
    function automatic logic at_most_one_w(input logic [WIDTH-1:0] x);
        return ((x & (x - {{(WIDTH-1){1'b0}}, 1'b1})) == {WIDTH{1'b0}});
    endfunction

    function automatic logic at_most_one_t(input logic [WIDTH-2:0] x);
        return ((x & (x - {{(WIDTH-2){1'b0}}, 1'b1})) == {(WIDTH-1){1'b0}});
    endfunction

    logic [WIDTH-2:0] edges_s;

    // Adjacent-bit transitions; a thermometer pattern has zero or one of them.
    always_comb begin
        edges_s = q_i[WIDTH-2:0] ^ q_i[WIDTH-1:1];
        if (mode_i == MODE_JOHNSON) begin
            legal_o = at_most_one_t(edges_s);
            home_o  = {WIDTH{1'b0}};
        end else begin
            legal_o = (q_i != {WIDTH{1'b0}}) && at_most_one_w(q_i);
            home_o  = {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule : shift_state_chk

// File: rtl/shift_counter_n.sv
// Parametrised ring / Johnson shift counter with direction, enable, parallel
// load, illegal-state detection (optional self-correction) and a wrap pulse.
module shift_counter_n
    import shift_counter_n_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter bit AUTO_CORRECT = 1'b1
) (
    input  logic             clk_i,
    input  logic             ori_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             wrap_o,
    output logic             err_o
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic             legal_s;
    logic [WIDTH-1:0] home_s;
    logic             twist_s;
    logic [WIDTH-1:0] shifted_s;

    shift_state_chk #(.WIDTH(WIDTH)) u_chk (
        .q_i     (q_q),
        .mode_i  (mode_i),
        .legal_o (legal_s),
        .home_o  (home_s)
    );

    // Next state: reset > load > enabled step > hold.
    always_comb begin
        q_d       = q_q;
        wrap_d    = 1'b0;
        err_d     = 1'b0;
        twist_s   = (mode_i == MODE_JOHNSON);
        if (dir_i == 1'b0) begin
            shifted_s = {q_q[WIDTH-2:0], q_q[WIDTH-1] ^ twist_s};
        end else begin
            shifted_s = {q_q[0] ^ twist_s, q_q[WIDTH-1:1]};
        end

        if (ori_i) begin
            q_d = home_s;
        end else if (load_i) begin
            q_d = d_i;
        end else if (en_i) begin
            if (legal_s) begin
                q_d    = shifted_s;
                wrap_d = (shifted_s == home_s);
            end else begin
                err_d = 1'b1;
                // Without correction the illegal pattern keeps circulating.
                q_d   = AUTO_CORRECT ? home_s : shifted_s;
            end
        end else begin
            q_d = q_q;
        end
    end

    // State and flag registers.
    always_ff @(posedge clk_i) begin
        q_q    <= q_d;
        wrap_q <= wrap_d;
        err_q  <= err_d;
    end

    assign q_o    = q_q;
    assign wrap_o = wrap_q;
    assign err_o  = err_q;

endmodule : shift_counter_n

// File: tb/tb_shift_counter_n.sv
// Scoreboard bench: a 4-bit self-correcting counter and an 8-bit flag-only
// counter share stimulus; a behavioural model predicts each cycle's outputs.
module tb_shift_counter_n;

    typedef struct packed {
        logic [7:0] q;
        logic       w;
        logic       e;
    } res_t;

    typedef struct packed {
        res_t r4;
        res_t r8;
    } exp_t;

    logic       clk = 1'b0;
    logic       ori_s = 1'b1, en_s = 1'b0, dir_s = 1'b0, mode_s = 1'b0, load_s = 1'b0;
    logic [7:0] d_s = 8'h00;
    logic [3:0] q4_s;
    logic [7:0] q8_s;
    logic       w4_s, e4_s, w8_s, e8_s;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    logic [7:0] m4 = 8'h00;
    logic [7:0] m8 = 8'h00;

    always #5 clk = ~clk;

    shift_counter_n #(.WIDTH(4), .AUTO_CORRECT(1'b1)) dut4 (
        .clk_i(clk), .ori_i(ori_s), .en_i(en_s), .dir_i(dir_s), .mode_i(mode_s),
        .load_i(load_s), .d_i(d_s[3:0]), .q_o(q4_s), .wrap_o(w4_s), .err_o(e4_s)
    );

    shift_counter_n #(.WIDTH(8), .AUTO_CORRECT(1'b0)) dut8 (
        .clk_i(clk), .ori_i(ori_s), .en_i(en_s), .dir_i(dir_s), .mode_i(mode_s),
        .load_i(load_s), .d_i(d_s), .q_o(q8_s), .wrap_o(w8_s), .err_o(e8_s)
    );

    // Legal states enumerated directly: one-hot for ring, the 2*w thermometers for Johnson.
    function automatic bit is_legal(input logic [7:0] q, input int w, input bit mode);
        int ones = 0;
        int mask = (1 << w) - 1;
        if (!mode) begin
            for (int i = 0; i < w; i++) ones += int'(q[i]);
            return ones == 1;
        end
        for (int k = 0; k <= w; k++) begin
            if (int'(q) == ((1 << k) - 1) || int'(q) == (mask ^ ((1 << k) - 1))) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic res_t model(input logic [7:0] q, input bit ori, input bit load,
                                   input logic [7:0] d, input bit en, input bit dir,
                                   input bit mode, input int w, input bit ac);
        res_t r;
        int   mask = (1 << w) - 1;
        int   home = mode ? 0 : 1;
        int   qi = int'(q);
        int   nq;
        r.q = q; r.w = 1'b0; r.e = 1'b0;
        if (ori) r.q = 8'(home);
        else if (load) r.q = 8'(int'(d) & mask);
        else if (en) begin
            if (!dir) nq = ((qi * 2) & mask) | (((qi >> (w - 1)) & 1) ^ int'(mode));
            else      nq = (qi / 2) | ((((qi & 1) ^ int'(mode))) << (w - 1));
            if (is_legal(q, w, mode)) begin
                r.q = 8'(nq);
                r.w = (nq == home);
            end else begin
                r.e = 1'b1;
                r.q = ac ? 8'(home) : 8'(nq);
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit ori, input bit load, input logic [7:0] d,
                        input bit en, input bit dir, input bit mode);
        exp_t e;
        @(negedge clk);
        ori_s = ori; load_s = load; d_s = d; en_s = en; dir_s = dir; mode_s = mode;
        e.r4 = model(m4, ori, load, d & 8'h0f, en, dir, mode, 4, 1'b1);
        e.r8 = model(m8, ori, load, d, en, dir, mode, 8, 1'b0);
        m4 = e.r4.q;
        m8 = e.r8.q;
        sb.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge that has a prediction outstanding is compared.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("q4",    {4'd0, q4_s}, e.r4.q);
            chk("wrap4", {7'd0, w4_s}, {7'd0, e.r4.w});
            chk("err4",  {7'd0, e4_s}, {7'd0, e.r4.e});
            chk("q8",    q8_s,         e.r8.q);
            chk("wrap8", {7'd0, w8_s}, {7'd0, e.r8.w});
            chk("err8",  {7'd0, e8_s}, {7'd0, e.r8.e});
        end
    end

    initial begin
        // Ring, up: 0001 0010 0100 1000 0001
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        settle();
        chk("lit_ring_wrap_q", {4'd0, q4_s}, 8'h01);
        chk("lit_ring_wrap_w", {7'd0, w4_s}, 8'h01);

        // Johnson full period, then reverse at 0011
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++)  step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        settle();
        chk("lit_john_rev_q", {4'd0, q4_s}, 8'h00);

        // Illegal load in ring mode
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h06, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        settle();
        chk("lit_corrected_q", {4'd0, q4_s}, 8'h02);

        // Mode changes mid-run
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Hold, load without enable, reset beats load and enable
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'hff, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'h5a, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h08, 1'b1, 1'b0, 1'b0);

        // Long ring runs (8-bit wraps every 8), then 8'h03 with no correction
        for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++)  step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            bit nmode;
            nmode = ($urandom_range(0, 19) == 0) ? !mode_s : mode_s;
            step($urandom_range(0, 29) == 0, $urandom_range(0, 11) == 0,
                 8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), nmode);
        end

        @(negedge clk);
        en_s = 1'b0; load_s = 1'b0; ori_s = 1'b0;
        settle();
        settle();
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_shift_counter_n
